// File: rtl/spio_uart_tx_arb_pkg.sv
// Shared packet width and port encoding for the two-requester UART transmit arbiter.
// PKT_LEN normally comes from the shared UART header; the fallback keeps this file self-contained.
`ifndef PKT_LEN
`define PKT_LEN 72
`endif

package spio_uart_tx_arb_pkg;

  localparam int PKT_W = `PKT_LEN;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_t;

  function automatic port_t other_port(input port_t p);
    return (p == PORT0) ? PORT1 : PORT0;
  endfunction

endpackage

// File: rtl/spio_uart_tx_arb.sv
// Two-input round-robin arbiter feeding one registered valid/ready stage towards the UART.
// Per-port counters record how many packets each requester has had accepted.
module spio_uart_tx_arb
  import spio_uart_tx_arb_pkg::*;
#(
  parameter int CNT_BITS = 16
) (
  input  logic                CLK_IN,
  input  logic                RESET_IN,
  input  logic [PKT_W-1:0]    IN0_DATA_IN,
  input  logic                IN0_VLD_IN,
  output logic                IN0_RDY_OUT,
  input  logic [PKT_W-1:0]    IN1_DATA_IN,
  input  logic                IN1_VLD_IN,
  output logic                IN1_RDY_OUT,
  output logic [PKT_W-1:0]    TX_DATA_OUT,
  output logic                TX_VLD_OUT,
  input  logic                TX_RDY_IN,
  input  logic                SYNCHRONISING_IN,
  output logic [CNT_BITS-1:0] IN0_CNT_OUT,
  output logic [CNT_BITS-1:0] IN1_CNT_OUT
);

  logic                r_vld;
  logic [PKT_W-1:0]    r_data;
  port_t               r_prio;
  logic [CNT_BITS-1:0] r_cnt0;
  logic [CNT_BITS-1:0] r_cnt1;

  logic  w_load_en;
  logic  w_grant_vld;
  port_t w_grant;
  logic  w_xfer0;
  logic  w_xfer1;

  // The output register may reload in the same cycle the UART takes its current packet.
  assign w_load_en = !SYNCHRONISING_IN && (!r_vld || TX_RDY_IN);

  // NOTE: give every always_comb output a default first so no path leaves it unassigned (latch).
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant     = r_prio;
    unique case ({IN1_VLD_IN, IN0_VLD_IN})
      2'b01:   begin w_grant_vld = 1'b1; w_grant = PORT0;  end
      2'b10:   begin w_grant_vld = 1'b1; w_grant = PORT1;  end
      2'b11:   begin w_grant_vld = 1'b1; w_grant = r_prio; end
      default: ;
    endcase
  end

  assign IN0_RDY_OUT = w_load_en && w_grant_vld && (w_grant == PORT0);
  assign IN1_RDY_OUT = w_load_en && w_grant_vld && (w_grant == PORT1);
  assign w_xfer0     = IN0_RDY_OUT && IN0_VLD_IN;
  assign w_xfer1     = IN1_RDY_OUT && IN1_VLD_IN;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      r_vld  <= 1'b0;
      r_data <= '0;
      r_prio <= PORT0;
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (w_load_en) begin
      if (w_xfer0) begin
        r_data <= IN0_DATA_IN;
        r_vld  <= 1'b1;
        r_prio <= other_port(PORT0);
        r_cnt0 <= r_cnt0 + CNT_BITS'(1);
      end else if (w_xfer1) begin
        r_data <= IN1_DATA_IN;
        r_vld  <= 1'b1;
        r_prio <= other_port(PORT1);
        r_cnt1 <= r_cnt1 + CNT_BITS'(1);
      end else begin
        r_vld  <= 1'b0;
      end
    end else if (r_vld && TX_RDY_IN) begin
      // Link is synchronising: the held packet still drains, but nothing new is loaded.
      r_vld <= 1'b0;
    end
  end

  assign TX_DATA_OUT = r_data;
  assign TX_VLD_OUT  = r_vld;
  assign IN0_CNT_OUT = r_cnt0;
  assign IN1_CNT_OUT = r_cnt1;

endmodule

// File: tb/tb_spio_uart_tx_arb.sv
// Self-checking bench for spio_uart_tx_arb: directed scenarios plus random traffic against a
// transaction-level model (held packet, tie-break owner, per-port accepted counts).
module tb_spio_uart_tx_arb;
  import spio_uart_tx_arb_pkg::*;

  localparam int CB = 4;

  logic             CLK_IN = 1'b0;
  logic             RESET_IN = 1'b0;
  logic [PKT_W-1:0] IN0_DATA_IN = '0;
  logic             IN0_VLD_IN = 1'b0;
  logic             IN0_RDY_OUT;
  logic [PKT_W-1:0] IN1_DATA_IN = '0;
  logic             IN1_VLD_IN = 1'b0;
  logic             IN1_RDY_OUT;
  logic [PKT_W-1:0] TX_DATA_OUT;
  logic             TX_VLD_OUT;
  logic             TX_RDY_IN = 1'b0;
  logic             SYNCHRONISING_IN = 1'b0;
  logic [CB-1:0]    IN0_CNT_OUT;
  logic [CB-1:0]    IN1_CNT_OUT;

  spio_uart_tx_arb #(.CNT_BITS(CB)) dut (
    .CLK_IN          (CLK_IN),
    .RESET_IN        (RESET_IN),
    .IN0_DATA_IN     (IN0_DATA_IN),
    .IN0_VLD_IN      (IN0_VLD_IN),
    .IN0_RDY_OUT     (IN0_RDY_OUT),
    .IN1_DATA_IN     (IN1_DATA_IN),
    .IN1_VLD_IN      (IN1_VLD_IN),
    .IN1_RDY_OUT     (IN1_RDY_OUT),
    .TX_DATA_OUT     (TX_DATA_OUT),
    .TX_VLD_OUT      (TX_VLD_OUT),
    .TX_RDY_IN       (TX_RDY_IN),
    .SYNCHRONISING_IN(SYNCHRONISING_IN),
    .IN0_CNT_OUT     (IN0_CNT_OUT),
    .IN1_CNT_OUT     (IN1_CNT_OUT)
  );

  always #5 CLK_IN = ~CLK_IN;

  int total = 0;
  int bad   = 0;

  // Model: the packet the UART currently sees, who wins the next tie, and accepted counts.
  logic             m_held;
  logic [PKT_W-1:0] m_data;
  int               m_tie_owner;
  int               m_cnt [2];
  int               m_order [$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PKT_W-1:0] rnd_pkt();
    return PKT_W'({$urandom, $urandom, $urandom});
  endfunction

  // Called at posedge+1; returns at the following posedge+1 with outputs checked.
  task automatic step(input logic v0, input logic v1, input logic [PKT_W-1:0] d0,
                      input logic [PKT_W-1:0] d1, input logic rdy, input logic sync);
    logic can_take;
    int   winner;
    IN0_VLD_IN = v0;  IN1_VLD_IN = v1;
    IN0_DATA_IN = d0; IN1_DATA_IN = d1;
    TX_RDY_IN = rdy;  SYNCHRONISING_IN = sync;
    #2;
    can_take = !sync && (!m_held || rdy);
    winner = -1;
    if (can_take) begin
      if (v0 && v1) winner = m_tie_owner;
      else if (v0)  winner = 0;
      else if (v1)  winner = 1;
    end
    check("in0_rdy", 128'(IN0_RDY_OUT), 128'(winner == 0));
    check("in1_rdy", 128'(IN1_RDY_OUT), 128'(winner == 1));
    @(posedge CLK_IN);
    #1;
    if (winner >= 0) begin
      m_held = 1'b1;
      m_data = (winner == 0) ? d0 : d1;
      m_tie_owner = 1 - winner;
      m_cnt[winner] = (m_cnt[winner] + 1) % (1 << CB);
      m_order.push_back(winner);
    end else if (m_held && rdy) begin
      m_held = 1'b0;
    end
    check("tx_vld", 128'(TX_VLD_OUT), 128'(m_held));
    if (m_held) check("tx_data", 128'(TX_DATA_OUT), 128'(m_data));
    check("cnt0", 128'(IN0_CNT_OUT), 128'(m_cnt[0]));
    check("cnt1", 128'(IN1_CNT_OUT), 128'(m_cnt[1]));
  endtask

  // Asserted mid-cycle; the output must clear without waiting for a clock edge.
  task automatic do_reset();
    IN0_VLD_IN = 1'b0; IN1_VLD_IN = 1'b0;
    RESET_IN = 1'b1;
    #1;
    check("rst_vld", 128'(TX_VLD_OUT), 128'(0));
    check("rst_data", 128'(TX_DATA_OUT), 128'(0));
    check("rst_cnt0", 128'(IN0_CNT_OUT), 128'(0));
    check("rst_cnt1", 128'(IN1_CNT_OUT), 128'(0));
    m_held = 1'b0; m_data = '0; m_tie_owner = 0;
    m_cnt[0] = 0; m_cnt[1] = 0;
    m_order.delete();
    @(posedge CLK_IN);
    #1;
    RESET_IN = 1'b0;
  endtask

  initial begin
    logic [PKT_W-1:0] p0, p1, held;

    #3;
    do_reset();

    // Both requesters saturating: strict alternation starting at port 0.
    p0 = rnd_pkt(); p1 = rnd_pkt();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, p0, p1, 1'b1, 1'b0);
      check("alt_data", 128'(TX_DATA_OUT), (i % 2 == 0) ? 128'(p0) : 128'(p1));
    end
    check("alt_cnt0", 128'(IN0_CNT_OUT), 128'(3));
    check("alt_cnt1", 128'(IN1_CNT_OUT), 128'(3));

    // Single requester on port 1, one-cycle latency.
    do_reset();
    p1 = PKT_W'(8'hA5);
    step(1'b0, 1'b1, '0, p1, 1'b1, 1'b0);
    check("a5_vld", 128'(TX_VLD_OUT), 128'(1));
    check("a5_data", 128'(TX_DATA_OUT[7:0]), 128'(8'hA5));
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    check("a5_cnt0", 128'(IN0_CNT_OUT), 128'(0));
    check("a5_drop", 128'(TX_VLD_OUT), 128'(0));

    // Back-pressure: held packet stays put, both inputs refused.
    p0 = rnd_pkt(); p1 = rnd_pkt();
    step(1'b1, 1'b0, p0, p1, 1'b1, 1'b0);
    held = p0;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, rnd_pkt(), rnd_pkt(), 1'b0, 1'b0);
    check("stall_data", 128'(TX_DATA_OUT), 128'(held));

    // Synchronising: drain the held packet, accept nothing until the link is usable.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, p0, p1, 1'b0, 1'b1);
    check("sync_hold", 128'(TX_VLD_OUT), 128'(1));
    step(1'b1, 1'b1, p0, p1, 1'b1, 1'b1);
    check("sync_drain", 128'(TX_VLD_OUT), 128'(0));
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, p0, p1, 1'b1, 1'b1);
    step(1'b1, 1'b1, p0, p1, 1'b1, 1'b0);
    check("sync_resume", 128'(TX_VLD_OUT), 128'(1));

    // Reset during a stall discards the held packet; first tie afterwards goes to port 0.
    step(1'b1, 1'b1, p0, p1, 1'b0, 1'b0);
    IN0_VLD_IN = 1'b1; IN1_VLD_IN = 1'b1; TX_RDY_IN = 1'b0;
    #2;
    do_reset();
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    check("post_rst_empty", 128'(TX_VLD_OUT), 128'(0));
    p0 = rnd_pkt(); p1 = rnd_pkt();
    step(1'b1, 1'b1, p0, p1, 1'b1, 1'b0);
    check("post_rst_tie", 128'(TX_DATA_OUT), 128'(p0));

    // Counter wrap: bring port 0 to all-ones, then one more transfer.
    do_reset();
    for (int i = 0; i < (1 << CB) - 1; i++) step(1'b1, 1'b0, rnd_pkt(), '0, 1'b1, 1'b0);
    check("wrap_ones", 128'(IN0_CNT_OUT), 128'((1 << CB) - 1));
    step(1'b1, 1'b0, rnd_pkt(), '0, 1'b1, 1'b0);
    check("wrap_zero", 128'(IN0_CNT_OUT), 128'(0));

    // Random traffic; also track the worst run of other-port grants seen by a waiting requester.
    do_reset();
    begin
      int wait0, wait1;
      wait0 = 0; wait1 = 0;
      for (int i = 0; i < 400; i++) begin
        logic v0, v1;
        int   n;
        v0 = ($urandom_range(0, 3) != 0);
        v1 = ($urandom_range(0, 3) != 0);
        n  = m_order.size();
        step(v0, v1, rnd_pkt(), rnd_pkt(), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 9) == 0));
        if (m_order.size() > n) begin
          if (m_order[n] == 1 && v0) wait0++; else wait0 = 0;
          if (m_order[n] == 0 && v1) wait1++; else wait1 = 0;
        end
        if (v0 && v1 && (wait0 > 1 || wait1 > 1)) begin
          check("fair_wait", 128'(wait0 > 1 || wait1 > 1), 128'(0));
          wait0 = 0; wait1 = 0;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spio_uart_tx_arb.md
SPIO_UART_TX_ARB -- requirements
Module: spio_uart_tx_arb

Interface
REQ-001 Parameter CNT_BITS, default 16, width of each per-port forwarded-packet counter.
REQ-002 Packet width SHALL be `PKT_LEN, taken from the shared UART header; it is not a parameter.
REQ-003 CLK_IN  input  1  single clock; all state SHALL be clocked on its rising edge.
REQ-004 RESET_IN  input  1  reset, asynchronous, active-high.
REQ-005 IN0_DATA_IN  input  `PKT_LEN  packet from requester 0.
REQ-006 IN0_VLD_IN  input  1  requester 0 valid.
REQ-007 IN0_RDY_OUT  output  1  requester 0 ready.
REQ-008 IN1_DATA_IN, IN1_VLD_IN, IN1_RDY_OUT  same widths and directions  requester 1 stream.
REQ-009 TX_DATA_OUT  output  `PKT_LEN  packet to the UART transmit port.
REQ-010 TX_VLD_OUT  output  1  packet valid to the UART.
REQ-011 TX_RDY_IN  input  1  UART transmit ready.
REQ-012 SYNCHRONISING_IN  input  1  UART link synchronisation status; high means link not usable.
REQ-013 IN0_CNT_OUT, IN1_CNT_OUT  output  CNT_BITS  packets accepted from each requester.

Function
REQ-014 A transfer on any stream SHALL occur on a rising edge where VLD and RDY are both high.
REQ-015 The output stage SHALL be a single register holding TX_DATA_OUT and TX_VLD_OUT.
REQ-016 load_en SHALL be (!SYNCHRONISING_IN) && (!TX_VLD_OUT || TX_RDY_IN), so one packet per cycle is sustained.
REQ-017 Grant, combinational: only IN0 valid -> IN0; only IN1 valid -> IN1; both valid -> port indicated by priority register prio; neither valid -> none.
REQ-018 INn_RDY_OUT SHALL be load_en && grant==n; at most one RDY high per cycle.
REQ-019 On a transfer from port n, the register SHALL load INn_DATA_IN, TX_VLD_OUT SHALL go to 1, and prio SHALL become the other port.
REQ-020 prio SHALL change only on an input transfer.
REQ-021 When load_en is high and no input transfers, TX_VLD_OUT SHALL go to 0.
REQ-022 Latency from input transfer to TX_VLD_OUT high SHALL be exactly 1 cycle.
REQ-023 While TX_VLD_OUT is high and TX_RDY_IN is low, TX_DATA_OUT and TX_VLD_OUT SHALL hold.
REQ-024 While SYNCHRONISING_IN is high, no input SHALL be accepted.
REQ-025 While SYNCHRONISING_IN is high, a packet already held SHALL remain valid until TX_RDY_IN accepts it; it is never withdrawn.
REQ-026 INn_CNT_OUT SHALL increment by 1 on each port-n transfer and wrap from all-ones to 0.
REQ-027 With both requesters continuously valid and the output continuously ready, grants SHALL strictly alternate.
REQ-028 No requester SHALL wait more than one other-port transfer while its VLD is held.
REQ-029 Inputs SHALL be treated as synchronous to CLK_IN; no synchronisers in this block.

Reset
REQ-030 RESET_IN SHALL asynchronously set TX_VLD_OUT=0, prio=port 0, IN0_CNT_OUT=0 and IN1_CNT_OUT=0.
REQ-031 TX_DATA_OUT SHALL reset to 0.
REQ-032 A packet held at reset assertion SHALL be discarded and not re-emitted after reset.
REQ-033 The first tie after reset SHALL be granted to port 0.

Structure
REQ-034 `PKT_LEN SHALL come from the shared UART header; no new shared constants are introduced.
REQ-035 The block SHALL be a single module with no sub-modules; the output register and arbiter are inline.

Verification
REQ-036 Link up, TX_RDY_IN=1, IN0 and IN1 both valid for 6 cycles -> TX_DATA_OUT order 0,1,0,1,0,1; each counter = 3.
REQ-037 Only IN1 valid, packet 0xA5 in low byte -> TX_VLD_OUT high 1 cycle after transfer carrying 0xA5; IN0_CNT_OUT stays 0.
REQ-038 TX_RDY_IN held low for 10 cycles with a packet held -> TX_DATA_OUT stable; both INn_RDY_OUT low throughout.
REQ-039 SYNCHRONISING_IN=1 with a packet held and both inputs valid -> held packet drains on TX_RDY_IN; no input accepted until SYNCHRONISING_IN falls.
REQ-040 Preload IN0_CNT_OUT to all-ones via 2^CNT_BITS-1 transfers, then one more transfer -> counter reads 0.
REQ-041 Assert RESET_IN mid-stall with TX_VLD_OUT high -> TX_VLD_OUT falls immediately; after release the first tie goes to port 0.
